// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline boundary register: valid/ready handshake,
// optional two-entry skid buffer, synchronous flush inserting a bubble.
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128,
    parameter bit SKID   = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              main_v, main_v_n;
    logic [CTRL_W-1:0] main_c, main_c_n;
    logic [DATA_W-1:0] main_d, main_d_n;
    logic              skid_v, skid_v_n;
    logic [CTRL_W-1:0] skid_c, skid_c_n;
    logic [DATA_W-1:0] skid_d, skid_d_n;
    logic              rdy_q;
    logic [1:0]        occ_q;
    logic              accept;
    logic              release_e;

    // With SKID the ready is a flop; without it, one AND/OR from out_ready.
    assign in_ready  = SKID ? rdy_q : (out_ready || !main_v);
    assign accept    = in_valid && in_ready;
    assign release_e = main_v && out_ready;

    assign out_valid = main_v;
    assign out_ctrl  = main_c;
    assign out_data  = main_d;
    assign occupancy = occ_q;

    always_comb begin
        main_v_n = main_v;
        main_c_n = main_c;
        main_d_n = main_d;
        skid_v_n = skid_v;
        skid_c_n = skid_c;
        skid_d_n = skid_d;
        if (flush) begin
            main_v_n = 1'b0;
            main_c_n = '0;
            skid_v_n = 1'b0;
        end else if (SKID && skid_v) begin
            if (release_e) begin
                main_v_n = 1'b1;
                main_c_n = skid_c;
                main_d_n = skid_d;
                skid_v_n = 1'b0;
            end
        end else if (!main_v || release_e) begin
            if (accept) begin
                main_v_n = 1'b1;
                main_c_n = in_ctrl;
                main_d_n = in_data;
            end else if (main_v) begin
                // Bubble: control goes quiet, data keeps its last value.
                main_v_n = 1'b0;
                main_c_n = '0;
            end
        end else if (SKID && accept) begin
            skid_v_n = 1'b1;
            skid_c_n = in_ctrl;
            skid_d_n = in_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            main_v <= 1'b0;
            main_c <= '0;
            main_d <= '0;
            skid_v <= 1'b0;
            skid_c <= '0;
            skid_d <= '0;
            rdy_q  <= 1'b1;
            occ_q  <= 2'd0;
        end else begin
            main_v <= main_v_n;
            main_c <= main_c_n;
            main_d <= main_d_n;
            skid_v <= skid_v_n;
            skid_c <= skid_c_n;
            skid_d <= skid_d_n;
            rdy_q  <= !skid_v_n;
            occ_q  <= {1'b0, main_v_n} + {1'b0, skid_v_n};
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances driven in
// parallel, each checked against its own queue-based reference.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [7:0]   c;
        logic [127:0] d;
    } ent_t;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_ctrl = '0;
    logic [127:0] in_data = '0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b0;

    logic         ir1, ov1, ir0, ov0;
    logic [7:0]   oc1, oc0;
    logic [127:0] od1, od0;
    logic [1:0]   occ1, occ0;

    int nchk = 0;
    int nfail = 0;

    ent_t         q1[$];
    ent_t         q0[$];
    logic [127:0] l1 = '0;
    logic [127:0] l0 = '0;
    bit           acc1, acc0;

    always #5 CLK = ~CLK;

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(1'b1)) dut1 (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(ir1),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .flush(flush),
        .out_valid(ov1), .out_ready(out_ready),
        .out_ctrl(oc1), .out_data(od1),
        .occupancy(occ1)
    );

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(1'b0)) dut0 (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(ir0),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .flush(flush),
        .out_valid(ov0), .out_ready(out_ready),
        .out_ctrl(oc0), .out_data(od0),
        .occupancy(occ0)
    );

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_outs();
        chk("s1_valid", 128'(ov1), 128'(q1.size() > 0));
        chk("s1_ctrl", 128'(oc1), 128'(q1.size() > 0 ? q1[0].c : 8'h00));
        chk("s1_data", od1, l1);
        chk("s1_occ", 128'(occ1), 128'(q1.size()));
        chk("s0_valid", 128'(ov0), 128'(q0.size() > 0));
        chk("s0_ctrl", 128'(oc0), 128'(q0.size() > 0 ? q0[0].c : 8'h00));
        chk("s0_data", od0, l0);
        chk("s0_occ", 128'(occ0), 128'(q0.size()));
    endtask

    // One clock: pre-edge ready check, edge, model update, output check.
    task automatic cyc();
        bit   rs, fl, rel1, rel0, r1, r0;
        ent_t e;
        #1;
        r1 = (q1.size() < 2);
        r0 = out_ready || (q0.size() == 0);
        if (RST) begin
            chk("s1_in_ready", 128'(ir1), 128'(r1));
            chk("s0_in_ready", 128'(ir0), 128'(r0));
        end
        rs   = RST;
        fl   = flush;
        e    = '{c: in_ctrl, d: in_data};
        acc1 = rs && in_valid && r1;
        acc0 = rs && in_valid && r0;
        rel1 = (q1.size() > 0) && out_ready;
        rel0 = (q0.size() > 0) && out_ready;
        @(posedge CLK);
        if (!rs) begin
            q1.delete();
            q0.delete();
            l1 = '0;
            l0 = '0;
            acc1 = 0;
            acc0 = 0;
        end else if (fl) begin
            q1.delete();
            q0.delete();
            acc1 = 0;
            acc0 = 0;
        end else begin
            if (rel1) void'(q1.pop_front());
            if (acc1) q1.push_back(e);
            if (rel0) void'(q0.pop_front());
            if (acc0) q0.push_back(e);
        end
        if (q1.size() > 0) l1 = q1[0].d;
        if (q0.size() > 0) l0 = q0[0].d;
        @(negedge CLK);
        check_outs();
    endtask

    task automatic offer(logic [7:0] c, logic [127:0] d);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        bit c_taken;

        // Reset held two cycles with junk on the input.
        RST = 1'b0;
        offer(8'hFF, 128'hDEAD);
        cyc();
        cyc();
        RST = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_valid", 128'(ov1), 128'(0));
        chk("rst_ctrl", 128'(oc1), 128'(0));
        chk("rst_data", od1, 128'(0));
        chk("rst_occ", 128'(occ1), 128'(0));
        chk("rst_ready", 128'(ir1), 128'(1));
        cyc();

        // Streaming at full rate.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            offer(8'(i), 128'(i));
            cyc();
            chk("stream_data", od1, 128'(i));
            chk("stream_occ", 128'(occ1), 128'(1));
        end
        in_valid = 1'b0;
        cyc();
        cyc();

        // Backpressure: A to main, B to skid, C refused.
        out_ready = 1'b0;
        offer(8'h0A, 128'hA);
        cyc();
        offer(8'h0B, 128'hB);
        cyc();
        offer(8'h0C, 128'hC);
        cyc();
        chk("bp_occ", 128'(occ1), 128'(2));
        chk("bp_ready", 128'(ir1), 128'(0));
        chk("bp_head", od1, 128'hA);
        out_ready = 1'b1;
        c_taken = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = !c_taken;
            cyc();
            if (acc1) c_taken = 1;
        end
        chk("bp_c_taken", 128'(c_taken), 128'(1));
        in_valid = 1'b0;
        cyc();
        cyc();

        // Flush with two entries held and D offered.
        out_ready = 1'b0;
        offer(8'h5A, 128'h111);
        cyc();
        offer(8'h5A, 128'h222);
        cyc();
        chk("fl_occ_pre", 128'(occ1), 128'(2));
        chk("fl_ctrl_pre", 128'(oc1), 128'h5A);
        flush = 1'b1;
        offer(8'h0D, 128'hD);
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 128'(ov1), 128'(0));
        chk("fl_ctrl", 128'(oc1), 128'(0));
        chk("fl_occ", 128'(occ1), 128'(0));
        chk("fl_data", od1, 128'h111);
        out_ready = 1'b1;
        cyc();
        cyc();

        // Bubble after a lone entry.
        offer(8'h3C, 128'hB0B);
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("bub_valid", 128'(ov1), 128'(0));
        chk("bub_ctrl", 128'(oc1), 128'(0));
        chk("bub_data", od1, 128'hB0B);

        // SKID=0 replace-in-place.
        out_ready = 1'b0;
        offer(8'h21, 128'hF1);
        cyc();
        cyc();
        chk("s0_full_ready", 128'(ir0), 128'(0));
        out_ready = 1'b1;
        offer(8'h0E, 128'hE);
        #1;
        chk("s0_comb_ready", 128'(ir0), 128'(1));
        cyc();
        chk("s0_e_valid", 128'(ov0), 128'(1));
        chk("s0_e_data", od0, 128'hE);
        in_valid = 1'b0;
        cyc();

        // Reset in mid-operation.
        out_ready = 1'b0;
        offer(8'h77, 128'h77);
        cyc();
        cyc();
        RST = 1'b0;
        cyc();
        RST = 1'b1;
        in_valid = 1'b0;
        chk("mid_rst_occ", 128'(occ1), 128'(0));
        chk("mid_rst_data", od1, 128'(0));
        cyc();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            in_ctrl   = 8'($urandom);
            in_data   = rnd128();
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 19) == 0;
            RST       = $urandom_range(0, 99) != 0;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
